// File: rtl/motor_regbank_pkg.sv
// motor_regbank_pkg: shared address map and bit positions for the motor register bank.
package motor_regbank_pkg;
    localparam int ADDR_A        = 0;
    localparam int ADDR_B        = 1;
    localparam int ADDR_SET      = 2;
    localparam int ADDR_CTRL     = 3;
    localparam int ADDR_SNAP     = 4;
    localparam int ADDR_STATUS   = 5;
    localparam int ADDR_ENC_BASE = 8;
    localparam int CTRL_OPENLOOP  = 0;
    localparam int CTRL_BRUSHLESS = 1;
    localparam int CTRL_WDOG_EN   = 2;
    localparam int STATUS_TRIP = 0;
endpackage

// File: rtl/motor_wdog.sv
// motor_wdog: setpoint watchdog; pulses expire once after WDOG_CYCLES cycles without a kick.
// Ports: clk, rst_n (async active-low), kick (SET write), en (watchdog enable), expire (1-cycle pulse).
module motor_wdog #(
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic held_q, held_d;
    // held_q keeps the counter parked after a trip so expire fires only once per idle period
    always_comb begin
        expire = en && !kick && !held_q && cnt_q == LAST;
        cnt_d  = (kick || !en) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        held_d = (kick || !en) ? 1'b0 : (held_q || expire);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            held_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            held_q <= held_d;
        end
    end
endmodule

// File: rtl/avalon_motor_regbank.sv
// avalon_motor_regbank: Avalon-MM register bank for PI gains, setpoint, mode flags and encoder snapshots.
// Ports: clk, rst_n (async active-low); Avalon slave cs_n/rd_n/wr_n/addr/wrdata/rddata/rddata_valid;
//        code (live encoder counts, ch0 in LSBs); A, B, set, z_openloop, z_brushless, wdog_trip outputs.
module avalon_motor_regbank
    import motor_regbank_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int A_RST       = 170,
    parameter int B_RST       = 100,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wrdata,
    output logic [DATA_W-1:0]        rddata,
    output logic                     rddata_valid,
    input  logic [NUM_CH*DATA_W-1:0] code,
    output logic [DATA_W-1:0]        A,
    output logic [DATA_W-1:0]        B,
    output logic [DATA_W-1:0]        set,
    output logic                     z_openloop,
    output logic                     z_brushless,
    output logic                     wdog_trip
);
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, set_q, set_d, rddata_q, rddata_d, rd_val, ctrl_val;
    logic [DATA_W-1:0] snap_q [NUM_CH];
    logic [DATA_W-1:0] snap_d [NUM_CH];
    logic [15:0] snap_cnt_q, snap_cnt_d;
    logic openloop_q, openloop_d, brushless_q, brushless_d, wdog_en_q, wdog_en_d;
    logic trip_q, trip_d, rddata_valid_q, rddata_valid_d;
    logic wr, rd, wr_ctrl, wr_snap, wr_status, kick, expire;
    motor_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
        .clk(clk), .rst_n(rst_n), .kick(kick), .en(wdog_en_q), .expire(expire)
    );
    always_comb begin
        wr        = !cs_n && !wr_n;
        rd        = !cs_n && !rd_n && wr_n;
        kick      = wr && addr == ADDR_W'(ADDR_SET);
        wr_ctrl   = wr && addr == ADDR_W'(ADDR_CTRL);
        wr_snap   = wr && addr == ADDR_W'(ADDR_SNAP);
        wr_status = wr && addr == ADDR_W'(ADDR_STATUS);
        ctrl_val = '0;
        ctrl_val[CTRL_OPENLOOP]  = openloop_q;
        ctrl_val[CTRL_BRUSHLESS] = brushless_q;
        ctrl_val[CTRL_WDOG_EN]   = wdog_en_q;
        rd_val = addr == ADDR_W'(ADDR_A)      ? a_q :
                 addr == ADDR_W'(ADDR_B)      ? b_q :
                 addr == ADDR_W'(ADDR_SET)    ? set_q :
                 addr == ADDR_W'(ADDR_CTRL)   ? ctrl_val :
                 addr == ADDR_W'(ADDR_SNAP)   ? DATA_W'(snap_cnt_q) :
                 addr == ADDR_W'(ADDR_STATUS) ? DATA_W'(trip_q) : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_W'(ADDR_ENC_BASE + i)) rd_val = snap_q[i];
            snap_d[i] = wr_snap ? code[i*DATA_W +: DATA_W] : snap_q[i];
        end
        a_d         = (wr && addr == ADDR_W'(ADDR_A)) ? wrdata : a_q;
        b_d         = (wr && addr == ADDR_W'(ADDR_B)) ? wrdata : b_q;
        // the watchdog never expires in a kick cycle, so trip and SET write are exclusive
        set_d       = expire ? '0 : kick ? wrdata : set_q;
        openloop_d  = expire ? 1'b1 : wr_ctrl ? wrdata[CTRL_OPENLOOP] : openloop_q;
        brushless_d = wr_ctrl ? wrdata[CTRL_BRUSHLESS] : brushless_q;
        wdog_en_d   = wr_ctrl ? wrdata[CTRL_WDOG_EN] : wdog_en_q;
        trip_d      = expire ? 1'b1 : (wr_status && wrdata[STATUS_TRIP]) ? 1'b0 : trip_q;
        snap_cnt_d  = wr_snap ? snap_cnt_q + 16'd1 : snap_cnt_q;
        rddata_d       = rd ? rd_val : rddata_q;
        rddata_valid_d = rd;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q            <= DATA_W'(A_RST);
            b_q            <= DATA_W'(B_RST);
            set_q          <= '0;
            openloop_q     <= 1'b0;
            brushless_q    <= 1'b1;
            wdog_en_q      <= 1'b0;
            trip_q         <= 1'b0;
            snap_cnt_q     <= '0;
            rddata_q       <= '0;
            rddata_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
        end else begin
            a_q            <= a_d;
            b_q            <= b_d;
            set_q          <= set_d;
            openloop_q     <= openloop_d;
            brushless_q    <= brushless_d;
            wdog_en_q      <= wdog_en_d;
            trip_q         <= trip_d;
            snap_cnt_q     <= snap_cnt_d;
            rddata_q       <= rddata_d;
            rddata_valid_q <= rddata_valid_d;
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= snap_d[i];
        end
    end
    assign A            = a_q;
    assign B            = b_q;
    assign set          = set_q;
    assign z_openloop   = openloop_q;
    assign z_brushless  = brushless_q;
    assign wdog_trip    = trip_q;
    assign rddata       = rddata_q;
    assign rddata_valid = rddata_valid_q;
endmodule
